fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 25 ++
 rtl/fetch_stage_buffer.sv | 62 ++++++
 rtl/fetch_stage.sv | 119 +++++++++++
 tb/tb_fetch_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared core definitions for the instruction fetch stage: bus widths,
// instruction field positions and the fetch FSM state encoding.
package fetch_stage_pkg;

  localparam int ADDR_W     = 32;
  localparam int INSTR_W    = 16;
  localparam int OPCODE_W   = 7;
  localparam int OPERANDS_W = 9;
  localparam int OPCODE_LSB = 9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // no request outstanding
    S_REQ  = 2'd1,  // request outstanding, data will be kept
    S_DROP = 2'd2   // request outstanding, data will be discarded
  } fetch_state_t;

  function automatic logic [OPCODE_W-1:0] instr_opcode(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1:OPCODE_LSB];
  endfunction

  function automatic logic [OPERANDS_W-1:0] instr_operands(input logic [INSTR_W-1:0] instr);
    return instr[OPERANDS_W-1:0];
  endfunction

endpackage

// File: rtl/fetch_stage_buffer.sv
// Two-entry instruction FIFO, each entry tagged with the PC it was fetched
// from. Flush wins over push/pop; a push and pop in one cycle keep the count.
module fetch_buffer
  import fetch_stage_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  output logic [1:0]         count,
  output logic [ADDR_W-1:0]  head_pc,
  output logic [INSTR_W-1:0] head_instr
);

  logic [ADDR_W-1:0]  pc_mem    [2];
  logic [INSTR_W-1:0] instr_mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign do_pop     = pop && (count != 2'd0);
  assign do_push    = push && ((count != 2'd2) || do_pop);
  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

  // Storage, pointers and occupancy; storage is cleared so the presented
  // fields read as zero after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        pc_mem[wr_ptr]    <= push_pc;
        instr_mem[wr_ptr] <= push_instr;
        wr_ptr            <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one word read at a time, buffers up to two
// returned words with their PCs and presents the oldest to decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_W-1:0]     redirect_pc,
  output logic                  imem_req,
  output logic [ADDR_W-1:0]     imem_addr,
  input  logic                  imem_ack,
  input  logic [INSTR_W-1:0]    imem_data,
  output logic                  instr_valid,
  output logic [OPCODE_W-1:0]   opcode,
  output logic [OPERANDS_W-1:0] operands,
  output logic [ADDR_W-1:0]     pc_out
);

  fetch_state_t       state;
  fetch_state_t       state_next;
  logic [ADDR_W-1:0]  pc;          // address of the next request to issue
  logic               issue;
  logic [ADDR_W-1:0]  issue_addr;
  logic               push;
  logic               pop;
  logic               full_after_push;
  logic [1:0]         count;
  logic [ADDR_W-1:0]  head_pc;
  logic [INSTR_W-1:0] head_instr;

  assign instr_valid     = (count != 2'd0);
  assign pop             = instr_valid && !stall && !redirect;
  assign full_after_push = pop ? (count == 2'd2) : (count != 2'd0);
  assign imem_req        = (state != S_IDLE);
  assign opcode          = instr_opcode(head_instr);
  assign operands        = instr_operands(head_instr);
  assign pc_out          = head_pc;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next state, request issue and buffer push; a redirect discards any
  // concurrent ack and restarts fetching at redirect_pc.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    issue_addr = pc;
    push       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (redirect) begin
          issue      = 1'b1;
          issue_addr = redirect_pc;
          state_next = S_REQ;
        end else if (count != 2'd2) begin
          issue      = 1'b1;
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (redirect) begin
          if (imem_ack) begin
            issue      = 1'b1;
            issue_addr = redirect_pc;
          end else begin
            state_next = S_DROP;
          end
        end else if (imem_ack) begin
          push = 1'b1;
          if (full_after_push) state_next = S_IDLE;
          else                 issue      = 1'b1;
        end
      end
      S_DROP: begin
        if (imem_ack) begin
          issue      = 1'b1;
          issue_addr = redirect ? redirect_pc : pc;
          state_next = S_REQ;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Request address and next-fetch PC; the address stays put until the
  // outstanding request is acked, even across a redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= RESET_PC;
      imem_addr <= RESET_PC;
    end else if (issue) begin
      imem_addr <= issue_addr;
      pc        <= issue_addr + 32'd1;
    end else if (redirect) begin
      pc <= redirect_pc;
    end
  end

  fetch_buffer u_buffer (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (redirect),
    .push_pc    (imem_addr),
    .push_instr (imem_data),
    .count      (count),
    .head_pc    (head_pc),
    .head_instr (head_instr)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the fetch unit.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h10;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        instr_valid;
  logic [6:0]  opcode;
  logic [8:0]  operands;
  logic [31:0] pc_out;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .operands    (operands),
    .pc_out      (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model: queue of fetched words, plus the outstanding request.
  typedef struct {
    logic [31:0] pc;
    logic [15:0] data;
  } ent_t;

  ent_t        q[$];
  bit          m_out;   // a request is outstanding
  bit          m_drop;  // its data will be thrown away
  logic [31:0] m_addr;
  logic [31:0] m_pc;

  function automatic logic [15:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    if (a == 32'h10) return 16'h2200;
    h = a * 32'h9E37_79B1;
    return h[31:16];
  endfunction

  task automatic model_reset();
    q.delete();
    m_out  = 1'b0;
    m_drop = 1'b0;
    m_addr = RST_PC;
    m_pc   = RST_PC;
  endtask

  task automatic model_issue(input logic [31:0] a);
    m_out  = 1'b1;
    m_addr = a;
    m_pc   = a + 32'd1;
  endtask

  task automatic model_edge(input bit st, input bit rd, input logic [31:0] rpc,
                            input bit ack, input logic [15:0] data);
    int pre;
    pre = q.size();
    if (rd) q.delete();
    else if (pre > 0 && !st) void'(q.pop_front());
    if (!m_out) begin
      if (rd) model_issue(rpc);
      else if (pre < 2) model_issue(m_pc);
    end else if (ack) begin
      if (!rd && !m_drop) begin
        q.push_back('{m_addr, data});
        if (q.size() >= 2) m_out = 1'b0;
        else model_issue(m_pc);
      end else begin
        m_drop = 1'b0;
        model_issue(rd ? rpc : m_pc);
      end
    end else if (rd) begin
      m_drop = 1'b1;
      m_pc   = rpc;
    end
  endtask

  task automatic compare_all();
    check_val("imem_req", 32'(imem_req), 32'(m_out));
    check_val("imem_addr", imem_addr, m_addr);
    check_val("instr_valid", 32'(instr_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      check_val("opcode", 32'(opcode), 32'(q[0].data) / 512);
      check_val("operands", 32'(operands), 32'(q[0].data) % 512);
      check_val("pc_out", pc_out, q[0].pc);
    end
  endtask

  // One clock: drive inputs at the falling edge, update the model at the
  // rising edge, compare at the next falling edge.
  // ack_mode: 0 never, 1 whenever requested, 2 random when requested, 3 forced.
  task automatic step(input bit st, input bit rd, input logic [31:0] rpc, input int ack_mode);
    bit a;
    case (ack_mode)
      0:       a = 1'b0;
      1:       a = imem_req;
      2:       a = imem_req && ($urandom_range(0, 99) < 60);
      default: a = 1'b1;
    endcase
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ack    = a;
    imem_data   = a ? mem_word(imem_addr) : 16'($urandom);
    @(posedge clk);
    model_edge(st, rd, rpc, a, imem_data);
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_req"}, 32'(imem_req), 32'd0);
    check_val({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check_val({tag, "_addr"}, imem_addr, RST_PC);
    check_val({tag, "_opcode"}, 32'(opcode), 32'd0);
    check_val({tag, "_operands"}, 32'(operands), 32'd0);
    check_val({tag, "_pc_out"}, pc_out, 32'd0);
  endtask

  // Asynchronous reset in the middle of a cycle, released on a falling edge.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1 check_reset_values("midreset");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] rpc;
    reset       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ack    = 1'b0;
    imem_data   = '0;
    model_reset();
    #12 check_reset_values("reset");
    @(negedge clk);
    reset = 1'b1;

    // First request after release; the stray ack in IDLE is ignored.
    step(0, 0, 0, 3);
    check_val("first_req", 32'(imem_req), 32'd1);
    check_val("first_addr", imem_addr, 32'h10);
    step(0, 0, 0, 1);
    check_val("seq_addr1", imem_addr, 32'h11);
    check_val("first_pc_out", pc_out, 32'h10);
    check_val("decode_opcode", 32'(opcode), 32'h11);
    check_val("decode_operands", 32'(operands), 32'h0);
    step(0, 0, 0, 1);
    check_val("seq_addr2", imem_addr, 32'h12);

    // Stall for five cycles: head frozen, buffer fills, requests stop.
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 1);
      check_val("stall_pc_out", pc_out, 32'h11);
    end
    check_val("stall_req_off", 32'(imem_req), 32'd0);
    check_val("stall_valid", 32'(instr_valid), 32'd1);
    step(0, 0, 0, 1);
    check_val("unstall_pc_out", pc_out, 32'h12);
    step(0, 0, 0, 1);

    // Reset during a request, then redirect while 0x12 is outstanding.
    do_reset();
    step(0, 0, 0, 3);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check_val("pend_addr", imem_addr, 32'h12);
    step(0, 1, 32'h40, 0);
    check_val("redir_valid", 32'(instr_valid), 32'd0);
    check_val("redir_hold_addr", imem_addr, 32'h12);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      check_val("drop_hold_addr", imem_addr, 32'h12);
      check_val("drop_valid", 32'(instr_valid), 32'd0);
    end
    step(0, 0, 0, 1);
    check_val("redir_addr", imem_addr, 32'h40);
    check_val("redir_valid2", 32'(instr_valid), 32'd0);
    step(0, 0, 0, 1);
    check_val("redir_pc_out", pc_out, 32'h40);

    // Ack and consume together with one entry buffered.
    step(0, 0, 0, 1);
    check_val("simul_valid", 32'(instr_valid), 32'd1);
    check_val("simul_pc_out", pc_out, 32'h41);

    // Wrap of the word address.
    step(0, 1, 32'hFFFF_FFFF, 0);
    step(0, 0, 0, 1);
    check_val("wrap_addr_hi", imem_addr, 32'hFFFF_FFFF);
    step(0, 0, 0, 1);
    check_val("wrap_addr", imem_addr, 32'h0);
    check_val("wrap_pc_out", pc_out, 32'hFFFF_FFFF);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) < 3) begin
        do_reset();
        step(0, 0, 0, 3);
      end else begin
        rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFE + 32'($urandom_range(0, 1)))
                                          : 32'($urandom);
        step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5, rpc, 2);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
